picosoc_timer: RTL and testbench

Programmable countdown timer that sits directly downstream of the SoC top on its external `iomem_*` bus and drives its `irq_5` input. It decodes a 256-byte window, acknowledges every access in that window with one wait state, and raises a level interrupt on expiry. Supports one-shot and auto-reload modes with a 16-bit prescaler.

---
 rtl/picosoc_timer_pkg.sv | 18 +
 rtl/picosoc_timer_prescaler.sv | 15 +
 rtl/picosoc_timer.sv | 78 +++++++
 tb/tb_picosoc_timer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_timer_pkg.sv
// picosoc_timer_pkg: register offsets, CTRL bit indices, bus FSM states and byte-strobe merge helper
package picosoc_timer_pkg;
  localparam logic [7:0] TMR_CTRL     = 8'h00;
  localparam logic [7:0] TMR_PRESCALE = 8'h04;
  localparam logic [7:0] TMR_LOAD     = 8'h08;
  localparam logic [7:0] TMR_COUNT    = 8'h0C;
  localparam logic [7:0] TMR_STATUS   = 8'h10;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
  typedef enum logic {IDLE, ACK} bus_state_t;
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/picosoc_timer_prescaler.sv
// picosoc_timer_prescaler: counts 0..div while en, tick when pcnt==div; ports clk, reset, en, restart, div[15:0] -> tick
module picosoc_timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        tick
);
  logic [15:0] pcnt;
  assign tick = en && pcnt == div;
  always_ff @(posedge clk or posedge reset)
    if (reset) pcnt <= '0;
    else pcnt <= (!en || restart || tick) ? '0 : pcnt + 16'd1;
endmodule

// File: rtl/picosoc_timer.sv
// picosoc_timer: iomem-mapped countdown timer (bus clk/reset/iomem_* in, iomem_ready/iomem_rdata/irq out)
module picosoc_timer
  import picosoc_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);
  bus_state_t state;
  logic en, reload, irq_en, expired;
  logic [15:0] prescale;
  logic [31:0] load, count, rd_mux;
  logic [7:0] off;
  logic sel, acc, wr, wr_ctrl, wr_count, clr, restart, tick, expire, tick_upd;
  assign off      = iomem_addr[7:0];
  assign sel      = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8];
  assign acc      = state == IDLE && sel;
  assign wr       = acc && |iomem_wstrb;
  assign wr_ctrl  = wr && off == TMR_CTRL && iomem_wstrb[0];
  assign wr_count = wr && off == TMR_COUNT;
  assign clr      = wr && off == TMR_STATUS && iomem_wstrb[0] && iomem_wdata[0];
  assign restart  = wr_ctrl && iomem_wdata[CTRL_EN] && !en;
  assign expire   = tick && count == '0;
  // A bus write to COUNT or EN on a tick edge overrides the tick's COUNT/EN update
  assign tick_upd = tick && !wr_ctrl && !wr_count;
  assign irq      = expired && irq_en;
  assign rd_mux = off == TMR_CTRL     ? {29'b0, irq_en, reload, en} :
                  off == TMR_PRESCALE ? {16'b0, prescale} :
                  off == TMR_LOAD     ? load :
                  off == TMR_COUNT    ? count :
                  off == TMR_STATUS   ? {31'b0, expired} : 32'b0;
  picosoc_timer_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (restart),
    .div     (prescale),
    .tick    (tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      en          <= 1'b0;
      reload      <= 1'b0;
      irq_en      <= 1'b0;
      expired     <= 1'b0;
      prescale    <= '0;
      load        <= '0;
      count       <= '0;
    end else begin
      state       <= acc ? ACK : IDLE;
      iomem_ready <= acc;
      if (acc) iomem_rdata <= rd_mux;
      if (wr_ctrl) begin
        en     <= iomem_wdata[CTRL_EN];
        reload <= iomem_wdata[CTRL_RELOAD];
        irq_en <= iomem_wdata[CTRL_IRQ_EN];
      end else if (tick_upd && expire && !reload) en <= 1'b0;
      if (wr && off == TMR_PRESCALE)
        prescale <= {iomem_wstrb[1] ? iomem_wdata[15:8] : prescale[15:8],
                     iomem_wstrb[0] ? iomem_wdata[7:0] : prescale[7:0]};
      if (wr && off == TMR_LOAD) load <= apply_wstrb(load, iomem_wdata, iomem_wstrb);
      if (wr_count) count <= apply_wstrb(count, iomem_wdata, iomem_wstrb);
      else if (tick_upd) count <= expire ? (reload ? load : '0) : count - 32'd1;
      // Expiry wins over a same-edge clear
      expired <= expire || (expired && !clr);
    end
endmodule

// File: tb/tb_picosoc_timer.sv
// tb_picosoc_timer: table vectors, directed corner sequences and randomized trials against an analytic timer model
module tb_picosoc_timer;
  localparam logic [31:0] B = 32'h0300_0000;
  logic clk = 0, reset = 1, valid = 0, ready, irq;
  logic [3:0] wstrb = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  int cyc = 0, checks = 0, errors = 0;

  picosoc_timer dut (
    .clk(clk), .reset(reset), .iomem_valid(valid), .iomem_ready(ready), .iomem_wstrb(wstrb),
    .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output int c);
    @(negedge clk);
    valid = 1; addr = a; wdata = d; wstrb = s; c = -1; r = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready) begin c = cyc; r = rdata; break; end
    end
    valid = 0; wstrb = 0;
    if (c < 0) begin
      checks++; errors++;
      $display("FAIL bus_timeout: addr %h got no ready required ready", a);
    end
    @(posedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int c);
    logic [31:0] r;
    bus(a, d, 4'hF, r, c);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r, output int c);
    bus(a, 32'h0, 4'h0, r, c);
  endtask

  task automatic wait_until(input int c);
    #1;
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic wait_irq(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (irq) begin c = cyc; break; end
    end
  endtask

  // Count after n ticks from a start value, derived from the countdown/reload rules
  function automatic logic [31:0] model_count(input int c0, input int l, input bit rl, input int n);
    if (n <= c0) return 32'(c0 - n);
    if (!rl) return 32'h0;
    return 32'(l - ((n - c0 - 1) % (l + 1)));
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  initial begin
    logic [31:0] r;
    int c, e, r1, r2, r3, x;
    bit seen;
    vecs[0] = '{B + 32'h04, 32'hFFFF_1234, 4'hF, 32'h0000_1234};
    vecs[1] = '{B + 32'h08, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD};
    vecs[2] = '{B + 32'h08, 32'h1122_3344, 4'h5, 32'hAA22_CC44};
    vecs[3] = '{B + 32'h0C, 32'h1234_56FF, 4'h1, 32'h0000_00FF};
    vecs[4] = '{B + 32'h00, 32'hFFFF_FFF6, 4'hF, 32'h0000_0006};
    vecs[5] = '{B + 32'h00, 32'h0000_0101, 4'h2, 32'h0000_0006};
    vecs[6] = '{B + 32'h00, 32'h0000_0000, 4'h1, 32'h0000_0000};
    vecs[7] = '{B + 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[8] = '{B + 32'h80, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[9] = '{B + 32'h10, 32'hFFFF_FFFE, 4'hF, 32'h0000_0000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, ready}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk) reset = 0;

    @(negedge clk);
    valid = 1; addr = B + 32'h14; wstrb = 0;
    @(posedge clk); #1;
    chk("unmapped_ready", {31'b0, ready}, 32'h1);
    chk("unmapped_rdata", rdata, 32'h0);
    valid = 0;
    @(posedge clk); #1;
    chk("ready_single_pulse", {31'b0, ready}, 32'h0);
    @(negedge clk);
    valid = 1; addr = 32'h0400_0000; seen = 0;
    repeat (6) begin @(posedge clk); #1; if (ready) seen = 1; end
    valid = 0;
    chk("outside_window_ready", {31'b0, seen}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      bus(vecs[i].a, vecs[i].d, vecs[i].s, r, c);
      rd(vecs[i].a, r, c);
      chk($sformatf("vec%0d_readback", i), r, vecs[i].exp);
    end

    @(negedge clk);
    valid = 1; addr = B + 32'h08; wdata = 32'h5555_5555; wstrb = 4'hF;
    @(posedge clk); #1;
    chk("ready_before_reset", {31'b0, ready}, 32'h1);
    #1 reset = 1;
    #1 chk("ready_async_reset", {31'b0, ready}, 32'h0);
    valid = 0; wstrb = 0;
    @(negedge clk) reset = 0;
    for (int i = 0; i < 5; i++) begin
      rd(B + 32'(4 * i), r, c);
      chk($sformatf("post_reset_reg%0d", i), r, 32'h0);
    end
    chk("post_reset_irq", {31'b0, irq}, 32'h0);

    wr(B + 32'h04, 0, c);
    wr(B + 32'h0C, 3, c);
    wr(B + 32'h00, 5, e);
    wait_until(e + 3);
    chk("oneshot_irq_before", {31'b0, irq}, 32'h0);
    wait_until(e + 4);
    chk("oneshot_irq_4th_tick", {31'b0, irq}, 32'h1);
    rd(B + 32'h00, r, c);
    chk("oneshot_ctrl_en_clear", r, 32'h4);
    rd(B + 32'h0C, r, c);
    chk("oneshot_count_zero", r, 32'h0);
    rd(B + 32'h10, r, c);
    chk("oneshot_status", r, 32'h1);
    wr(B + 32'h10, 1, c);
    #1 chk("oneshot_irq_cleared", {31'b0, irq}, 32'h0);

    wr(B + 32'h04, 2, c);
    wr(B + 32'h08, 4, c);
    wr(B + 32'h00, 7, e);
    wait_irq(r1);
    chk("reload_first_expiry", 32'(r1 - e), 32'd3);
    wr(B + 32'h10, 1, c);
    wait_irq(r2);
    chk("reload_period_1", 32'(r2 - r1), 32'd15);
    wr(B + 32'h10, 1, c);
    wait_irq(r3);
    chk("reload_period_2", 32'(r3 - r2), 32'd15);
    wr(B + 32'h10, 1, c);
    x = r3 + 15;
    wait_until(x - 1);
    wr(B + 32'h10, 1, c);
    chk("clear_on_expiry_edge", 32'(c), 32'(x));
    #1 chk("clear_vs_expiry_irq", {31'b0, irq}, 32'h1);
    rd(B + 32'h10, r, c);
    chk("clear_vs_expiry_status", r, 32'h1);

    wr(B + 32'h00, 0, c);
    wr(B + 32'h04, 2, c);
    wr(B + 32'h0C, 5, c);
    wr(B + 32'h00, 1, e);
    wait_until(e + 2);
    wr(B + 32'h0C, 32'h100, c);
    chk("count_write_on_tick_edge", 32'(c), 32'(e + 3));
    rd(B + 32'h0C, r, c);
    chk("count_write_wins", r, 32'h100);

    for (int t = 0; t < 20; t++) begin
      int p, l, c0, d, n;
      bit rl, ie;
      p = $urandom_range(0, 3); l = $urandom_range(0, 6); c0 = $urandom_range(0, 8);
      rl = 1'($urandom_range(0, 1)); ie = 1'($urandom_range(0, 1)); d = $urandom_range(0, 40);
      wr(B + 32'h00, 0, c);
      wr(B + 32'h04, 32'(p), c);
      wr(B + 32'h08, 32'(l), c);
      wr(B + 32'h0C, 32'(c0), c);
      wr(B + 32'h10, 1, c);
      wr(B + 32'h00, {29'b0, ie, rl, 1'b1}, e);
      repeat (d) @(posedge clk);
      rd(B + 32'h0C, r, c);
      n = (c - 1 - e) / (p + 1);
      chk($sformatf("rand%0d_count", t), r, model_count(c0, l, rl, n));
      rd(B + 32'h10, r, c);
      n = (c - 1 - e) / (p + 1);
      chk($sformatf("rand%0d_status", t), r, {31'b0, n > c0});
      #1;
      n = (c + 1 - e) / (p + 1);
      chk($sformatf("rand%0d_irq", t), {31'b0, irq}, {31'b0, ie && n > c0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
